// File: rtl/enemy_control_if.sv
// ============================================================================
// Module      : enemy_control_if
// Description : Phase-strobe bus between the enemy sequencer and enemy block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface enemy_control_if;
  logic       enable;
  logic       draw_done;
  logic       init;
  logic       idle;
  logic       gen_move;
  logic       apply_move;
  logic       draw;
  logic [7:0] frame_count;
  logic       overrun;
  logic       draw_timeout;

  modport master (
    input  enable, draw_done,
    output init, idle, gen_move, apply_move, draw,
    output frame_count, overrun, draw_timeout
  );

  modport slave (
    output enable, draw_done,
    input  init, idle, gen_move, apply_move, draw,
    input  frame_count, overrun, draw_timeout
  );
endinterface

`default_nettype wire

// File: rtl/enemy_control.sv
// ============================================================================
// Module      : enemy_control
// Description : Frame-paced sequencer for the enemy init/move/draw phases.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module enemy_control #(
  parameter int FRAME_CYCLES = 833333,
  parameter int MOVE_DIVIDE  = 4,
  parameter int DRAW_TIMEOUT = 65535
) (
  input  wire logic        clock,
  input  wire logic        reset,
  enemy_control_if.master  bus
);

  localparam int TICK_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(FRAME_CYCLES - 1);
  localparam logic [7:0]        c_div_last  = 8'(MOVE_DIVIDE - 1);
  localparam logic [15:0]       c_wdog_last = 16'(DRAW_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_INIT  = 3'd1,
    S_IDLE  = 3'd2,
    S_GEN   = 3'd3,
    S_APPLY = 3'd4,
    S_DRAW  = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic [7:0]        r_div;
  logic [7:0]        w_div_next;
  logic [15:0]       r_wdog;
  logic              w_done_ok;
  logic              w_expire;
  logic              w_fc_inc;
  logic              w_set_timeout;
  logic              w_set_overrun;

  logic              r_init;
  logic              r_idle;
  logic              r_gen_move;
  logic              r_apply_move;
  logic              r_draw;
  logic [7:0]        r_frame_count;
  logic              r_overrun;
  logic              r_draw_timeout;

  assign w_tick        = (r_tick_cnt == c_tick_last);
  // Watchdog is zero only on the DRAW entry cycle, so a stale done is ignored.
  assign w_done_ok     = bus.draw_done && (r_wdog != 16'd0);
  assign w_expire      = (r_wdog == c_wdog_last);
  assign w_set_overrun = w_tick && (r_state != S_IDLE) && (r_state != S_RST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_div_next    = r_div;
    w_fc_inc      = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_RST:   w_next = S_INIT;
      S_INIT:  w_next = S_IDLE;
      S_IDLE: begin
        if (w_tick && bus.enable) begin
          if (r_div == c_div_last) begin
            w_div_next = 8'd0;
            w_next     = S_GEN;
          end else begin
            w_div_next = r_div + 8'd1;
            w_next     = S_DRAW;
          end
        end
      end
      S_GEN:   w_next = S_APPLY;
      S_APPLY: w_next = S_DRAW;
      S_DRAW: begin
        if (w_done_ok) begin
          w_next   = S_IDLE;
          w_fc_inc = 1'b1;
        end else if (w_expire) begin
          w_next        = S_IDLE;
          w_set_timeout = 1'b1;
        end
      end
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick_cnt     <= '0;
      r_div          <= 8'd0;
      r_wdog         <= 16'd0;
      r_frame_count  <= 8'd0;
      r_overrun      <= 1'b0;
      r_draw_timeout <= 1'b0;
      r_init         <= 1'b0;
      r_idle         <= 1'b0;
      r_gen_move     <= 1'b0;
      r_apply_move   <= 1'b0;
      r_draw         <= 1'b0;
    end else begin
      r_tick_cnt     <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_div          <= w_div_next;
      r_wdog         <= (r_state == S_DRAW) ? r_wdog + 16'd1 : 16'd0;
      r_frame_count  <= r_frame_count + {7'd0, w_fc_inc};
      r_overrun      <= r_overrun | w_set_overrun;
      r_draw_timeout <= r_draw_timeout | w_set_timeout;
      // Phases are registered from the next state so they align with it.
      r_init         <= (w_next == S_INIT);
      r_idle         <= (w_next == S_IDLE);
      r_gen_move     <= (w_next == S_GEN);
      r_apply_move   <= (w_next == S_APPLY);
      r_draw         <= (w_next == S_DRAW);
    end
  end

  assign bus.init         = r_init;
  assign bus.idle         = r_idle;
  assign bus.gen_move     = r_gen_move;
  assign bus.apply_move   = r_apply_move;
  assign bus.draw         = r_draw;
  assign bus.frame_count  = r_frame_count;
  assign bus.overrun      = r_overrun;
  assign bus.draw_timeout = r_draw_timeout;

endmodule

`default_nettype wire

// File: tb/tb_enemy_control.sv
// ============================================================================
// Module      : tb_enemy_control
// Description : Directed self-checking bench for enemy_control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_enemy_control;

  localparam int FC = 16;
  localparam int MD = 2;
  localparam int DT = 32;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] exp_fc;
  int   model_div;

  enemy_control_if eif ();

  enemy_control #(
    .FRAME_CYCLES (FC),
    .MOVE_DIVIDE  (MD),
    .DRAW_TIMEOUT (DT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (eif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference divider: returns whether the next accepted tick is a move frame.
  function automatic bit accept_tick();
    bit mv;
    mv = (model_div == MD - 1);
    model_div = mv ? 0 : model_div + 1;
    return mv;
  endfunction

  task automatic chk_zero(input string tag);
    chk(tag, {17'd0, eif.init, eif.idle, eif.gen_move, eif.apply_move, eif.draw,
              eif.overrun, eif.draw_timeout, eif.frame_count}, 32'd0);
  endtask

  task automatic enter_sequence(input bit exp_move, input bit drop_en);
    int n = 0;
    while (eif.idle && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("leave_idle", eif.idle, 0);
    chk("gen_move", eif.gen_move, exp_move);
    if (exp_move) begin
      @(negedge clock);
      chk("apply_move", eif.apply_move, 1);
      if (drop_en) eif.enable = 1'b0;
      @(negedge clock);
    end
    chk("draw", eif.draw, 1);
  endtask

  // Pulses draw_done so that DRAW lasts exactly done_after cycles.
  task automatic run_frame(input bit exp_move, input int done_after, input bit drop_en);
    enter_sequence(exp_move, drop_en);
    repeat (done_after - 1) @(negedge clock);
    chk("draw_held", eif.draw, 1);
    eif.draw_done = 1'b1;
    @(negedge clock);
    eif.draw_done = 1'b0;
    exp_fc = exp_fc + 8'd1;
    chk("idle_after_done", eif.idle, 1);
    chk("frame_count", eif.frame_count, exp_fc);
  endtask

  // draw_done is held by the caller; measures how long DRAW lasts.
  task automatic run_tied(input bit exp_move, input int exp_len, input bit inc);
    int n = 0;
    enter_sequence(exp_move, 1'b0);
    while (eif.draw && n < 64) begin
      n++;
      @(negedge clock);
    end
    chk("draw_len", n, exp_len);
    chk("idle_after_draw", eif.idle, 1);
    if (inc) exp_fc = exp_fc + 8'd1;
    chk("frame_count", eif.frame_count, exp_fc);
  endtask

  task automatic release_and_init();
    reset = 1'b1;
    @(negedge clock);
    chk("init_pulse", {eif.init, eif.idle}, 2'b10);
    @(negedge clock);
    chk("idle_after_init", {eif.init, eif.idle}, 2'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int stuck;
    total         = 0;
    bad           = 0;
    exp_fc        = 8'd0;
    model_div     = 0;
    reset         = 1'b0;
    eif.enable    = 1'b0;
    eif.draw_done = 1'b0;

    // Reset and init
    repeat (5) @(negedge clock);
    chk_zero("reset_outputs");
    release_and_init();
    eif.enable = 1'b1;

    // Move cadence: N, M, N, M with a 4-cycle draw
    for (int i = 0; i < 4; i++) run_frame(accept_tick(), 4, 1'b0);
    chk("no_overrun_cadence", eif.overrun, 0);

    // Stale done: DRAW lasts exactly 2 cycles
    eif.draw_done = 1'b1;
    run_tied(accept_tick(), 2, 1'b1);
    run_tied(accept_tick(), 2, 1'b1);
    eif.draw_done = 1'b0;
    chk("no_overrun_stale", eif.overrun, 0);

    // Done on the watchdog's final cycle wins over expiry
    run_frame(accept_tick(), DT, 1'b0);
    chk("simul_no_timeout", eif.draw_timeout, 0);
    chk("simul_overrun", eif.overrun, 1);

    // Hang: watchdog abandons DRAW after DT cycles
    run_tied(accept_tick(), DT, 1'b0);
    chk("hang_timeout", eif.draw_timeout, 1);

    // Enable gating over several ticks
    eif.enable = 1'b0;
    stuck = 0;
    repeat (3 * FC + 2) begin
      @(negedge clock);
      if (!eif.idle) stuck++;
    end
    chk("gated_stays_idle", stuck, 0);
    eif.enable = 1'b1;
    run_frame(accept_tick(), 4, 1'b0);
    run_frame(accept_tick(), 4, 1'b1);
    chk("enable_dropped", eif.enable, 0);
    eif.enable = 1'b1;

    // Reset mid-DRAW
    enter_sequence(accept_tick(), 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk_zero("reset_mid_draw");
    repeat (3) @(negedge clock);
    chk_zero("reset_held");
    exp_fc    = 8'd0;
    model_div = 0;
    release_and_init();

    // 256 frames wrap the frame counter
    eif.draw_done = 1'b1;
    for (int i = 0; i < 256; i++) run_tied(accept_tick(), 2, 1'b1);
    eif.draw_done = 1'b0;
    chk("fc_wrapped", eif.frame_count, 0);
    chk("final_flags", {eif.overrun, eif.draw_timeout}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enemy_control.md
# enemy_control

Sequencer that drives the enemy subsystem's phase-strobe protocol (`init`, `idle`, `gen_move`, `apply_move`, `draw`) and consumes its `draw_done` completion. It is the initiator end of the interface the enemy block responds to. It sits between the frame timebase and the enemy block:
- paces movement at a fixed frame rate;
- serialises move generation, move application and redraw;
- flags frame overruns and hung draws.

## Interface
Parameters:
- `FRAME_CYCLES`, default 833333: clock cycles per frame tick (60 Hz at 50 MHz).
- `MOVE_DIVIDE`, default 4: frames per movement update. Legal range is 1..255.
- `DRAW_TIMEOUT`, default 65535: maximum cycles spent in DRAW waiting for `draw_done`.

Ports:
- `clock`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `enable`, input, 1: game running; gates the start of new frame sequences.
- `draw_done`, input, 1: enemy block has finished drawing all enemies. Level signal.
- `init`, output, 1: initialise enemies.
- `idle`, output, 1: enemies hold state.
- `gen_move`, output, 1: enemies compute the next move.
- `apply_move`, output, 1: enemies commit the move, gated by collision.
- `draw`, output, 1: enemies draw; held until `draw_done`.
- `frame_count`, output, 8: completed draw sequences, modulo 256.
- `overrun`, output, 1: sticky; a frame tick arrived outside IDLE.
- `draw_timeout`, output, 1: sticky; DRAW was abandoned by the watchdog.

## Operation
- States: RST, INIT, IDLE, GEN, APPLY, DRAW.
- Phase outputs are registered and one-hot: exactly one is high in every state except RST, where all are 0.
- Tick counter:
  - free-running, width `$clog2(FRAME_CYCLES)`;
  - counts 0..`FRAME_CYCLES`-1, then wraps;
  - `tick` is high for the one cycle when the count equals `FRAME_CYCLES`-1.
- Move divider: 8-bit, counts ticks accepted in IDLE, range 0..`MOVE_DIVIDE`-1.

Transitions:
- RST→INIT: unconditional.
- INIT→IDLE: unconditional.
- IDLE with `tick`&`enable`:
  - if the divider equals `MOVE_DIVIDE`-1: clear the divider and go to GEN;
  - otherwise: increment the divider and go to DRAW.
- IDLE with `tick`&!`enable`: stay in IDLE; the divider is unchanged.
- GEN→APPLY: unconditional.
- APPLY→DRAW: unconditional.
- DRAW→IDLE when `draw_done`=1:
  - increment `frame_count` (255 wraps to 0);
  - clear the watchdog.
- DRAW→IDLE when the watchdog reaches `DRAW_TIMEOUT`-1 without `draw_done`:
  - set `draw_timeout`;
  - `frame_count` is not incremented.

Watchdog:
- 16-bit counter.
- Counts only in DRAW; cleared on every entry to DRAW.

Boundary and priority rules:
- `tick` in any state other than IDLE or RST sets `overrun`. That tick is dropped: no divider change and no queued sequence.
- `enable` deasserted mid-sequence: the sequence runs to IDLE normally.
- `draw_done` high on the DRAW entry cycle is ignored. Only `draw_done` sampled while `draw` is already high counts. This covers a stale done level left over from the previous frame.
- `draw_done` and watchdog expiry in the same cycle: `draw_done` wins; `draw_timeout` is not set.
- `MOVE_DIVIDE`=1: every accepted tick goes through GEN and APPLY.
- Sticky flags clear only on reset.

## Timing
- Reset assertion (any time, including mid-DRAW) immediately forces:
  - state to RST;
  - all phase outputs to 0;
  - `frame_count`, `overrun`, `draw_timeout`, divider, tick counter and watchdog to 0.
- First rising edge after reset release: `init`=1 for exactly 1 cycle. The next cycle, `idle`=1.
- Latency from `tick` in IDLE:
  - move frame: `gen_move` high 1 cycle later, `apply_move` 2 cycles later, `draw` 3 cycles later;
  - non-move frame: `draw` high 1 cycle later.
- `draw_done` sampled high in DRAW: `idle`=1 and `frame_count` updated on the next cycle.
- Minimum DRAW duration is 2 cycles.

## Test plan
Use `FRAME_CYCLES`=16, `MOVE_DIVIDE`=2, `DRAW_TIMEOUT`=32 throughout.
- **Reset and init.** Hold `reset`=0 for 5 cycles, then release → all outputs 0 during reset; `init`=1 on the first cycle after release; `idle`=1 from the second cycle.
- **Move cadence.** `enable`=1; `draw_done` returned 4 cycles after each `draw` rise. Over 4 ticks → phase order: DRAW, then GEN, APPLY, DRAW, then DRAW, then GEN, APPLY, DRAW. `frame_count` reads 1, 2, 3, 4.
- **Stale done and hang.** `draw_done` tied to 1 → each DRAW lasts exactly 2 cycles.
  - Then tie `draw_done` to 0 → DRAW lasts 32 cycles.
  - Because DRAW (32 cycles) outlasts the 16-cycle frame, a tick arrives during DRAW and sets `overrun`=1.
  - Expected end state: `draw_timeout`=1, `frame_count` unchanged, return to IDLE.
- **Enable gating.** `enable`=0 for 3 ticks → no state leaves IDLE; divider unchanged.
  - Drop `enable` during APPLY → DRAW still occurs; `frame_count` still increments.
- **Simultaneous events.** `draw_done` rises on the watchdog's final cycle → `draw_timeout` stays 0; `frame_count` increments.
- **Reset mid-operation and wrap.** Assert `reset` mid-DRAW → all outputs 0 immediately; after release, `init` pulses again.
  - Run 256 frames → `frame_count` wraps from 255 to 0.
